ext_irq_ctrl: RTL and testbench

Multi-channel external interrupt controller; the parametrised successor to the single ExtIRQ/ExtlAck line on processor_arm. Synchronises NCH asynchronous request lines, latches them per channel (edge or level mode), arbitrates fixed or round-robin, and presents one request plus a cause code to the core. Sits between board-level interrupt sources and processor_arm's ExtIRQ/ExtlAck pins; adds masking, end-of-interrupt and overrun tracking.

---
 rtl/ext_irq_pkg.sv | 19 +
 rtl/irq_sync_edge.sv | 33 +++
 rtl/ext_irq_ctrl.sv | 124 ++++++++++++
 tb/tb_ext_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_pkg.sv
// Shared types and helpers for the external interrupt controller.
package ext_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

  // Channel index width; stays at least 1 bit even for degenerate channel counts.
  function automatic int unsigned idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic logic [31:0] cause_ext(input logic [31:0] id);
    return id;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line, plus a rising-edge pulse.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// Multi-channel external interrupt controller: sync, latch, mask, arbitrate and
// hand one request at a time to the core via ExtIRQ/ExtlAck/eoi.
module ext_irq_ctrl
  import ext_irq_pkg::*;
#(
  parameter int unsigned    NCH         = 8,
  parameter int unsigned    N           = 64,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [NCH-1:0] EDGE_MASK   = '1,
  parameter bit             RR_MODE     = 1'b0
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic [NCH-1:0] irq_in,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wdata,
  output logic [NCH-1:0] irq_en,
  output logic           ExtIRQ,
  input  logic           ExtlAck,
  input  logic           eoi,
  output logic [N-1:0]   irq_cause,
  input  logic           ovr_clr,
  output logic [NCH-1:0] overrun
);

  localparam int unsigned IDX_W = idx_w(NCH);

  logic [NCH-1:0] sync_lvl, sync_rise;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (CLOCK_50),
      .rst_n (reset),
      .d_in  (irq_in[gi]),
      .level (sync_lvl[gi]),
      .rise  (sync_rise[gi])
    );
  end

  state_e           state_q, state_d;
  logic [NCH-1:0]   pend_q, pend_d, ovr_q, ovr_d, en_q, en_d;
  logic [IDX_W-1:0] id_q, id_d, ptr_q, ptr_d, win, id_next;
  logic             irq_q, irq_d, win_vld;
  logic [N-1:0]     cause_q, cause_d;
  logic [NCH-1:0]   elig, ack_clr, elig_sh;
  int unsigned      j;

  // Search starts at the RR pointer (or 0 in fixed mode) and wraps.
  always_comb begin
    elig    = pend_q & en_q;
    win     = '0;
    win_vld = 1'b0;
    j       = 0;
    elig_sh = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      j       = ((RR_MODE ? 32'(ptr_q) : 32'd0) + off) % NCH;
      elig_sh = elig >> j;
      if (!win_vld && elig_sh[0]) begin
        win_vld = 1'b1;
        win     = IDX_W'(j);
      end
    end
  end

  always_comb begin
    id_next = (id_q == IDX_W'(NCH - 1)) ? '0 : id_q + 1'b1;
    ack_clr = (state_q == REQ && ExtlAck) ? ((NCH'(1) << id_q) & EDGE_MASK) : '0;
    // A fresh edge in the ack cycle re-arms the channel and is not an overrun.
    pend_d  = (EDGE_MASK & (sync_rise | (pend_q & ~ack_clr))) | (~EDGE_MASK & sync_lvl);
    ovr_d   = (ovr_q & ~{NCH{ovr_clr}}) | (EDGE_MASK & sync_rise & pend_q & ~ack_clr);
    en_d    = mask_we ? mask_wdata : en_q;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    irq_d   = irq_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: if (win_vld) begin
        id_d    = win;
        irq_d   = 1'b1;
        cause_d = N'(cause_ext(32'(win)));
        state_d = REQ;
      end
      REQ: if (ExtlAck) begin
        irq_d   = 1'b0;
        state_d = SVC;
        if (RR_MODE) ptr_d = id_next;
      end
      SVC: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovr_q   <= '0;
      en_q    <= '1;
      id_q    <= '0;
      ptr_q   <= '0;
      irq_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
    end
  end

  assign irq_en    = en_q;
  assign ExtIRQ    = irq_q;
  assign irq_cause = cause_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_ext_irq_ctrl;

  localparam logic [7:0] EMASK = 8'hEF;  // channel 4 level-triggered

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_in, mask_wdata;
  logic        mask_we, ack, eoi, ovr_clr;
  logic [7:0]  en_f, ovr_f, en_r, ovr_r;
  logic        irq_f, irq_r;
  logic [63:0] cause_f, cause_r;

  always #5 clk = ~clk;

  ext_irq_ctrl #(.NCH(8), .N(64), .SYNC_STAGES(2), .EDGE_MASK(EMASK), .RR_MODE(1'b0)) u_fix (
    .CLOCK_50(clk), .reset(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .irq_en(en_f), .ExtIRQ(irq_f), .ExtlAck(ack), .eoi(eoi), .irq_cause(cause_f),
    .ovr_clr(ovr_clr), .overrun(ovr_f));

  ext_irq_ctrl #(.NCH(8), .N(64), .SYNC_STAGES(2), .EDGE_MASK(EMASK), .RR_MODE(1'b1)) u_rr (
    .CLOCK_50(clk), .reset(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .irq_en(en_r), .ExtIRQ(irq_r), .ExtlAck(ack), .eoi(eoi), .irq_cause(cause_r),
    .ovr_clr(ovr_clr), .overrun(ovr_r));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = fixed, 1 = round-robin) ----------------
  logic [7:0]  smp [3];          // input samples from the last three edges
  logic [7:0]  pend [2], movr [2], men [2];
  int          phase [2];        // 0 idle, 1 request outstanding, 2 in service
  int          lid [2], mptr [2];
  bit          mreq [2];
  logic [63:0] mcause [2];
  logic [7:0]  m_lvl, m_rise, m_ack, m_elig;
  int          m_w;

  function automatic int pick(input logic [7:0] e, input int base);
    int c;
    logic [7:0] t;
    for (int off = 0; off < 8; off++) begin
      c = (base + off) % 8;
      t = e >> c;
      if (t[0]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) smp[i] = 8'h00;
      for (int m = 0; m < 2; m++) begin
        pend[m] = 8'h00; movr[m] = 8'h00; men[m] = 8'hFF; phase[m] = 0;
        lid[m] = 0; mptr[m] = 0; mreq[m] = 1'b0; mcause[m] = 64'd0;
      end
    end else begin
      m_lvl  = smp[1];
      m_rise = smp[1] & ~smp[2];
      for (int m = 0; m < 2; m++) begin
        m_ack   = (phase[m] == 1 && ack) ? ((8'h01 << lid[m]) & EMASK) : 8'h00;
        movr[m] = (ovr_clr ? 8'h00 : movr[m]) | (EMASK & m_rise & pend[m] & ~m_ack);
        m_elig  = pend[m] & men[m];
        pend[m] = (EMASK & (m_rise | (pend[m] & ~m_ack))) | (~EMASK & m_lvl);
        if (mask_we) men[m] = mask_wdata;
        case (phase[m])
          0: begin
            m_w = pick(m_elig, (m == 1) ? mptr[m] : 0);
            if (m_w >= 0) begin
              lid[m] = m_w; mreq[m] = 1'b1; mcause[m] = 64'(m_w); phase[m] = 1;
            end
          end
          1: if (ack) begin
            mreq[m] = 1'b0; phase[m] = 2;
            if (m == 1) mptr[m] = (lid[m] + 1) % 8;
          end
          default: if (eoi) phase[m] = 0;
        endcase
      end
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = irq_in;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en && rst_n === 1'b1) begin
      chk("cyc_f_irq",   64'(irq_f),   64'(mreq[0]));
      chk("cyc_f_cause", cause_f,      mcause[0]);
      chk("cyc_f_en",    64'(en_f),    64'(men[0]));
      chk("cyc_f_ovr",   64'(ovr_f),   64'(movr[0]));
      chk("cyc_r_irq",   64'(irq_r),   64'(mreq[1]));
      chk("cyc_r_cause", cause_r,      mcause[1]);
      chk("cyc_r_en",    64'(en_r),    64'(men[1]));
      chk("cyc_r_ovr",   64'(ovr_r),   64'(movr[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = irq_in | m;
    tick(1);
    irq_in = irq_in & ~m;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(1); ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(1); eoi = 1'b0;
  endtask

  task automatic wait_irq(input string nm);
    int k = 0;
    while (irq_f !== 1'b1 && k < 30) begin
      tick(1);
      k++;
    end
    chk(nm, 64'(irq_f), 64'd1);
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v; tick(1); mask_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    ack = 1'b0; eoi = 1'b0; ovr_clr = 1'b0;
    tick(3);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("rst_irq",   64'(irq_f), 64'd0);
    chk("rst_cause", cause_f,    64'd0);
    chk("rst_en",    64'(en_f),  64'hFF);
    chk("rst_ovr",   64'(ovr_r), 64'd0);
    tick(5);

    // Single edge pulse on channel 3: request three edges later.
    pulse(8'h08);
    tick(2);
    chk("s1_lat_lo", 64'(irq_f), 64'd0);
    tick(1);
    chk("s1_lat_hi",   64'(irq_f), 64'd1);
    chk("s1_cause",    cause_f,    64'd3);
    chk("s1_cause_rr", cause_r,    64'd3);
    tick(2);
    do_ack();
    chk("s1_ack_drop",  64'(irq_f), 64'd0);
    chk("s1_cause_hld", cause_f,    64'd3);
    tick(3);
    do_eoi();
    tick(6);
    chk("s1_no_rereq", 64'(irq_f), 64'd0);

    // Serve channel 2 alone so the round-robin pointer lands on 3.
    pulse(8'h04);
    wait_irq("s2_irq");
    chk("s2_cause_rr", cause_r, 64'd2);
    do_ack(); tick(1); do_eoi(); tick(3);

    // Channels 2 and 5 together: fixed picks 2 first, RR (pointer 3) picks 5 first.
    pulse(8'h24);
    wait_irq("s3_irq_a");
    chk("s3_fix_first", cause_f, 64'd2);
    chk("s3_rr_first",  cause_r, 64'd5);
    do_ack(); do_eoi();
    wait_irq("s3_irq_b");
    chk("s3_fix_second", cause_f, 64'd5);
    chk("s3_rr_second",  cause_r, 64'd2);
    do_ack(); do_eoi(); tick(3);

    // Second edge on channel 1 before ack sets overrun; only one service results.
    pulse(8'h02);
    tick(2);
    pulse(8'h02);
    wait_irq("s4_irq");
    chk("s4_cause", cause_f, 64'd1);
    tick(3);
    chk("s4_ovr_set", 64'(ovr_f), 64'h02);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    chk("s4_ovr_clr", 64'(ovr_f), 64'h00);
    do_ack(); tick(1); do_eoi(); tick(6);
    chk("s4_one_svc", 64'(irq_f), 64'd0);

    // Masked channel 0 stays pending and fires once re-enabled.
    write_mask(8'hFE);
    chk("s5_en_fe", 64'(en_f), 64'hFE);
    pulse(8'h01);
    tick(6);
    chk("s5_masked", 64'(irq_f), 64'd0);
    write_mask(8'hFF);
    chk("s5_en_ff",   64'(en_f),  64'hFF);
    chk("s5_not_yet", 64'(irq_f), 64'd0);
    tick(1);
    chk("s5_fire",  64'(irq_f), 64'd1);
    chk("s5_cause", cause_f,    64'd0);
    do_ack(); do_eoi(); tick(3);

    // Level channel 4 held across eoi re-requests on the next cycle; no third after release.
    irq_in[4] = 1'b1;
    wait_irq("s6_irq");
    chk("s6_cause", cause_f, 64'd4);
    do_ack(); tick(2); do_eoi();
    chk("s6_idle_lo", 64'(irq_f), 64'd0);
    tick(1);
    chk("s6_rereq",       64'(irq_f), 64'd1);
    chk("s6_rereq_cause", cause_f,    64'd4);
    irq_in[4] = 1'b0;
    do_ack(); tick(2); do_eoi(); tick(6);
    chk("s6_no_third", 64'(irq_f), 64'd0);

    // Reset while in REQ, with mask cleared and an overrun pending.
    pulse(8'h40);
    wait_irq("s7_irq");
    write_mask(8'h00);
    chk("s7_mask_keeps", 64'(irq_f), 64'd1);
    pulse(8'h40);
    tick(4);
    chk("s7_ovr", 64'(ovr_f), 64'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("s7_rst_irq_f", 64'(irq_f), 64'd0);
    chk("s7_rst_irq_r", 64'(irq_r), 64'd0);
    chk("s7_rst_en",    64'(en_f),  64'hFF);
    chk("s7_rst_ovr",   64'(ovr_f), 64'h00);
    chk("s7_rst_cause", cause_r,    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_ack();
    tick(6);
    chk("s7_ack_ignored", 64'(irq_f), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
